// File: rtl/rca_pkg.sv
// ============================================================================
// Module : rca_pkg
// Brief  : Shared constants for the ripple-carry adder block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 8;

endpackage : rca_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module : full_adder
// Brief  : Single-bit combinational full-adder cell.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign sum  = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule : full_adder

`default_nettype wire

// File: rtl/ripple_carry_adder.sv
// ============================================================================
// Module : ripple_carry_adder
// Brief  : WIDTH-bit ripple-carry adder with registered {cout,sum}.
//          Define RCA_OVERFLOW_EN to add the registered signed-overflow output ovf.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
`ifdef RCA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             cout
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_c[0] = cin;

  // Each cell consumes the carry produced by the cell below it: a pure ripple chain.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (w_c[i]),
        .sum  (w_s[i]),
        .cout (w_c[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_s;
      r_cout <= w_c[WIDTH];
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef RCA_OVERFLOW_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule : ripple_carry_adder

`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
// ============================================================================
// Module : tb_ripple_carry_adder
// Brief  : Scoreboard bench for ripple_carry_adder (WIDTH=8), with or without RCA_OVERFLOW_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ripple_carry_adder;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    string      nm;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  ripple_carry_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
`ifdef RCA_OVERFLOW_EN
    .ovf  (ovf),
`endif
    .cout (cout)
  );

`ifndef RCA_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] es, input logic ec, input logic eo);
    logic bad;
    checks++;
    bad = (sum !== es) || (cout !== ec);
`ifdef RCA_OVERFLOW_EN
    bad = bad || (ovf !== eo);
`endif
    if (bad) begin
      errors++;
      $display("FAIL %s: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
               nm, sum, cout, ovf, es, ec, eo);
    end
  endtask

  // Drive on the falling edge and queue the result due after the next rising edge.
  task automatic apply(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       input logic [7:0] es, input logic ec, input logic eo, input string nm);
    exp_t e;
    @(negedge clk);
    a = va; b = vb; cin = vc;
    e.s = es; e.c = ec; e.o = eo; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: outputs are valid every edge; compare whenever a result is owed.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_hold", 8'h00, 1'b0, 1'b0);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, e.s, e.c, e.o);
      end
    end
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] full;
    logic       eo;

    rst = 1'b0; a = 8'h5A; b = 8'hC3; cin = 1'b1;
    #1 rst = 1'b1;
    #1 chk("rst_async", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed {sum, cout, ovf}.
    apply(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "one_plus_one");
    apply(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_plus_one");
    apply(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, "aa_55_cin");
    apply(8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, "f0_0f");
    apply(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "ones_zero_cin");
    apply(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero_zero");
    apply(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "max_max_cin");
    apply(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_pos");
    apply(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "ovf_neg");
    apply(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_40_40");

    // Back-to-back random vectors with a reset pulse mid-stream.
    for (int i = 0; i < 256; i++) begin
      if (i == 128) begin
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_mid", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      eo = (ra[7] == rb[7]) && (full[7] != ra[7]);
      apply(ra, rb, rc, full[7:0], full[8], eo, "random");
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ripple_carry_adder

`default_nettype wire
